tabela_verdade_varredor: RTL and testbench
==========================================

Name: tabela_verdade_varredor

Overview:
- Sequential stimulus/response harness: the driving and reading end of a 4-input combinational function block (a, b, c, d -> y).
- On start, it drives every input combination in ascending order and waits a programmable settle time per vector.
- It samples the function output and assembles the full truth table plus a minterm count.
- Used on-board and in benches to characterise any single-output combinational circuit in the problem set.

Parameters:
- N_IN, 4, number of function inputs; vector index width.
- SETTLE, 1, idle cycles between driving a vector and sampling y; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- stim  output  N_IN  drives function inputs; stim[N_IN-1]=a ... stim[0]=d
- y  input  1  function output under test
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when the table is complete
- tabela  output  2**N_IN  truth table; bit i = y sampled with stim==i
- n_mintermos  output  N_IN+1  count of 1s in tabela

Behaviour:
- Reset (async, rst=1): state=IDLE; stim=0, busy=0, done=0, tabela=0, n_mintermos=0, settle counter=0.
- FSM states: IDLE, WAIT, SAMPLE, FIM.
- IDLE:
  - start=1 -> WAIT; clear tabela and n_mintermos; stim=0; load settle counter with SETTLE; busy=1 from the next cycle.
  - start=0 -> stay in IDLE.
- WAIT:
  - Hold stim; decrement the counter.
  - Counter==0 on entry or after decrement -> SAMPLE.
  - SETTLE=0 therefore spends zero WAIT cycles (WAIT is skipped straight to SAMPLE).
- SAMPLE (one cycle):
  - tabela[stim] <= y.
  - If y=1, n_mintermos <= n_mintermos+1.
  - stim==2**N_IN-1 -> FIM.
  - Otherwise stim <= stim+1, reload counter, go to WAIT (or SAMPLE directly if SETTLE=0).
- FIM (one cycle): done=1, busy=0, then -> IDLE.
  - tabela and n_mintermos hold until the next accepted start.
  - stim returns to 0 in IDLE.
- Timing: each vector costs SETTLE+1 cycles. done is high exactly 2**N_IN*(SETTLE+1)+1 cycles after the edge that accepted start.
- start while busy or in FIM: ignored; no restart, no error.
- start held high continuously: a new sweep begins the cycle after FIM.
- Count arithmetic: n_mintermos is N_IN+1 bits, so the all-ones function (16) fits; it never wraps.
- stim wrap-around: the increment never wraps; the last vector exits to FIM.
- Reset mid-sweep: immediate return to reset values; the partial table is discarded; no done pulse.

Optional Feature:
- Macro VARREDOR_COMPARA_EN.
- When defined, two extra ports are added:
  - esperado input 2**N_IN: golden table; sampled at the accepted start and held internally.
  - erro output 1: reset 0; cleared on start; set and held when any SAMPLE sees y != esperado[stim].
  - The first mismatching index is also captured in a debug register.
- When not defined, neither port exists and there is no comparison logic.

Decomposition:
- Shared package tabela_pkg holds:
  - the state enum (IDLE, WAIT, SAMPLE, FIM);
  - N_IN default constant;
  - table width constant 2**N_IN;
  - golden constant TABELA_P3 = 16'h450F.
- One natural sub-module: contador_settle (loadable down-counter with zero flag), instantiated once.

Test Plan:
- DUT y = a'b' + b'd' + a·c·d', SETTLE=1, pulse start -> tabela=16'h450F, n_mintermos=7, done exactly 33 cycles after the accepting edge, busy high throughout.
- y tied 0, SETTLE=0 -> tabela=16'h0000, n_mintermos=0, done 17 cycles after start; y tied 1 -> tabela=16'hFFFF, n_mintermos=16.
- Re-pulse start at cycle 10 of a sweep -> ignored; done still at cycle 33; table still 16'h450F.
- Assert rst while stim==5 -> all outputs 0 asynchronously, no done pulse; new start yields 16'h450F.
- start held high over two sweeps -> second sweep begins the cycle after FIM; both report 16'h450F.
- VARREDOR_COMPARA_EN, esperado=16'h450F with the DUT altered so y(14)=0 -> erro rises after the SAMPLE of vector 14; n_mintermos=6; captured index 14.

Source files
------------

// File: rtl/tabela_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Used by tabela_verdade_varredor and its settle counter.
package tabela_pkg;

  localparam int N_IN_PADRAO = 4;
  localparam int TAB_W = 2 ** N_IN_PADRAO;

  localparam logic [TAB_W-1:0] TABELA_P3 = 16'h450F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    FIM
  } estado_t;

endpackage

// File: rtl/tabela_verdade_varredor_contador_settle.sv
// Loadable down-counter with zero/one flags.
// Paces the settle interval between driving a vector and sampling it.
module contador_settle #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carga,
  input  logic         dec,
  input  logic [W-1:0] valor,
  output logic         zero,
  output logic         ultimo
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (carga) begin
      cnt <= valor;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero   = (cnt == '0);
  assign ultimo = (cnt == W'(1));

endmodule

// File: rtl/tabela_verdade_varredor.sv
// Sweeps all input vectors of a combinational block and records y.
// Optional golden compare enabled by VARREDOR_COMPARA_EN.
module tabela_verdade_varredor
  import tabela_pkg::*;
#(
  parameter int N_IN   = N_IN_PADRAO,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef VARREDOR_COMPARA_EN
  input  logic [2**N_IN-1:0]   esperado,
  output logic                 erro,
`endif
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tabela,
  output logic [N_IN:0]        n_mintermos
);

  localparam logic [N_IN-1:0] STIM_MAX = '1;
  localparam logic [3:0]      SETTLE_V = 4'(SETTLE);
  localparam logic            SEM_WAIT = (SETTLE == 0);

  estado_t estado;
  logic    aceita;
  logic    ultimo_vetor;
  logic    cnt_carga;
  logic    cnt_dec;
  logic    cnt_zero;
  logic    cnt_ultimo;

  assign aceita       = (estado == IDLE) && start;
  assign ultimo_vetor = (stim == STIM_MAX);
  assign cnt_carga    = aceita ||
                        ((estado == SAMPLE) && !ultimo_vetor);
  assign cnt_dec      = (estado == WAIT);

  contador_settle #(
    .W(4)
  ) u_contador (
    .clk   (clk),
    .rst   (rst),
    .carga (cnt_carga),
    .dec   (cnt_dec),
    .valor (SETTLE_V),
    .zero  (cnt_zero),
    .ultimo(cnt_ultimo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= IDLE;
      stim        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tabela      <= '0;
      n_mintermos <= '0;
    end else begin
      done <= 1'b0;
      unique case (estado)
        IDLE: begin
          stim <= '0;
          if (start) begin
            tabela      <= '0;
            n_mintermos <= '0;
            busy        <= 1'b1;
            estado      <= SEM_WAIT ? SAMPLE : WAIT;
          end
        end
        WAIT: begin
          // zero covers entry with an empty count, one covers the last tick
          if (cnt_zero || cnt_ultimo) begin
            estado <= SAMPLE;
          end
        end
        SAMPLE: begin
          tabela[stim] <= y;
          if (y) begin
            n_mintermos <= n_mintermos + 1'b1;
          end
          if (ultimo_vetor) begin
            estado <= FIM;
          end else begin
            stim   <= stim + 1'b1;
            estado <= SEM_WAIT ? SAMPLE : WAIT;
          end
        end
        FIM: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

`ifdef VARREDOR_COMPARA_EN
  logic [2**N_IN-1:0] esperado_q;
  logic [N_IN-1:0]    idx_erro;

  // only the first mismatch is latched into idx_erro
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esperado_q <= '0;
      erro       <= 1'b0;
      idx_erro   <= '0;
    end else if (aceita) begin
      esperado_q <= esperado;
      erro       <= 1'b0;
      idx_erro   <= '0;
    end else if ((estado == SAMPLE) && !erro &&
                 (y != esperado_q[stim])) begin
      erro     <= 1'b1;
      idx_erro <= stim;
    end
  end
`endif

endmodule

// File: tb/tb_tabela_verdade_varredor.sv
// Directed bench for tabela_verdade_varredor (SETTLE=1 and SETTLE=0).
// Define VARREDOR_COMPARA_EN to also exercise the golden compare.
module tb_tabela_verdade_varredor;
  import tabela_pkg::*;

  logic clk;
  logic rst;

  logic       start1, y1, busy1, done1;
  logic [3:0] stim1;
  logic [15:0] tab1;
  logic [4:0] n1;
  logic [1:0] modo1;

  logic       start0, y0, busy0, done0;
  logic [3:0] stim0;
  logic [15:0] tab0;
  logic [4:0] n0;
  logic [1:0] modo0;

`ifdef VARREDOR_COMPARA_EN
  logic [15:0] esp1, esp0;
  logic        erro1, erro0;
`endif

  int n_chk;
  int n_fail;

  tabela_verdade_varredor #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
`ifdef VARREDOR_COMPARA_EN
    .esperado   (esp1),
    .erro       (erro1),
`endif
    .start      (start1),
    .stim       (stim1),
    .y          (y1),
    .busy       (busy1),
    .done       (done1),
    .tabela     (tab1),
    .n_mintermos(n1)
  );

  tabela_verdade_varredor #(.N_IN(4), .SETTLE(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
`ifdef VARREDOR_COMPARA_EN
    .esperado   (esp0),
    .erro       (erro0),
`endif
    .start      (start0),
    .stim       (stim0),
    .y          (y0),
    .busy       (busy0),
    .done       (done0),
    .tabela     (tab0),
    .n_mintermos(n0)
  );

  // 0: a'b'+b'd'+acd', 1: const 0, 2: const 1, 3: mode 0 with y(14)=0
  function automatic logic func(input logic [1:0] m, input logic [3:0] s);
    logic a, b, c, d, p3;
    {a, b, c, d} = s;
    p3 = (~a & ~b) | (~b & ~d) | (a & c & ~d);
    case (m)
      2'd0: func = p3;
      2'd1: func = 1'b0;
      2'd2: func = 1'b1;
      default: func = p3 & (s != 4'd14);
    endcase
  endfunction

  always_comb y1 = func(modo1, stim1);
  always_comb y0 = func(modo0, stim0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    modo1 = 2'd0;
    modo0 = 2'd1;
`ifdef VARREDOR_COMPARA_EN
    esp1 = 16'h0;
    esp0 = 16'h0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({stim1, busy1, done1, tab1, n1} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_dut1: got stim=%h busy=%b done=%b tab=%h n=%0d want all 0",
               stim1, busy1, done1, tab1, n1);
    end
    n_chk++;
    if ({stim0, busy0, done0, tab0, n0} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_dut0: got stim=%h busy=%b done=%b tab=%h n=%0d want all 0",
               stim0, busy0, done0, tab0, n0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got busy=%b done=%b want 0 0", busy1, done1);
    end
  endtask

  task automatic test_p3;
    int kd;
    logic busy_ok;
    modo1 = 2'd0;
    kd = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        kd = k;
        break;
      end
      if (!busy1) busy_ok = 1'b0;
    end
    n_chk++;
    if (kd != 33) begin
      n_fail++;
      $display("FAIL p3_latency: got %0d want 33", kd);
    end
    n_chk++;
    if (!busy_ok || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL p3_busy: got during=%b at_done=%b want 1 0", busy_ok, busy1);
    end
    n_chk++;
    if (tab1 !== TABELA_P3 || n1 !== 5'd7) begin
      n_fail++;
      $display("FAIL p3_table: got %h/%0d want 450f/7", tab1, n1);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (done1 !== 1'b0 || stim1 !== 4'd0 || tab1 !== TABELA_P3) begin
      n_fail++;
      $display("FAIL p3_after: got done=%b stim=%h tab=%h want 0 0 450f",
               done1, stim1, tab1);
    end
  endtask

  task automatic test_const;
    int kd;
    for (int t = 0; t < 2; t++) begin
      modo0 = (t == 0) ? 2'd1 : 2'd2;
      kd = 0;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk);
        #1;
        if (done0) begin
          kd = k;
          break;
        end
      end
      n_chk++;
      if (kd != 17) begin
        n_fail++;
        $display("FAIL const%0d_latency: got %0d want 17", t, kd);
      end
      n_chk++;
      if (t == 0 && (tab0 !== 16'h0000 || n0 !== 5'd0)) begin
        n_fail++;
        $display("FAIL const0_table: got %h/%0d want 0000/0", tab0, n0);
      end else if (t == 1 && (tab0 !== 16'hFFFF || n0 !== 5'd16)) begin
        n_fail++;
        $display("FAIL const1_table: got %h/%0d want ffff/16", tab0, n0);
      end
    end
  endtask

  task automatic test_restart_ignorado;
    int kd;
    modo1 = 2'd0;
    kd = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        kd = k;
        break;
      end
      if (k == 9) start1 = 1'b1;
      if (k == 10) start1 = 1'b0;
    end
    n_chk++;
    if (kd != 33 || tab1 !== TABELA_P3) begin
      n_fail++;
      $display("FAIL restart_ignored: got %0d/%h want 33/450f", kd, tab1);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_no_resweep: got busy=%b want 0", busy1);
    end
  endtask

  task automatic test_reset_meio;
    logic achou;
    logic viu_done;
    achou = 1'b0;
    viu_done = 1'b0;
    modo1 = 2'd0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (stim1 == 4'd5) begin
        achou = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!achou) begin
      n_fail++;
      $display("FAIL midreset_reach5: got stim=%h want 5", stim1);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({stim1, busy1, done1, tab1, n1} !== 27'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got stim=%h busy=%b tab=%h n=%0d want 0",
               stim1, busy1, tab1, n1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) viu_done = 1'b1;
    end
    n_chk++;
    if (viu_done) begin
      n_fail++;
      $display("FAIL midreset_quiet: got activity=1 want 0");
    end
    test_p3();
  endtask

  task automatic test_back_to_back;
    int nd;
    int kd[2];
    logic [15:0] td[2];
    nd = 0;
    kd[0] = 0;
    kd[1] = 0;
    td[0] = '0;
    td[1] = '0;
    modo1 = 2'd0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 34) begin
        n_chk++;
        if (busy1 !== 1'b1 || tab1 !== 16'h0) begin
          n_fail++;
          $display("FAIL b2b_second_start: got busy=%b tab=%h want 1 0000",
                   busy1, tab1);
        end
      end
      if (done1) begin
        kd[nd] = k;
        td[nd] = tab1;
        nd++;
        if (nd == 2) begin
          start1 = 1'b0;
          break;
        end
      end
    end
    n_chk++;
    if (kd[0] != 33 || kd[1] != 67) begin
      n_fail++;
      $display("FAIL b2b_timing: got %0d,%0d want 33,67", kd[0], kd[1]);
    end
    n_chk++;
    if (td[0] !== TABELA_P3 || td[1] !== TABELA_P3) begin
      n_fail++;
      $display("FAIL b2b_tables: got %h,%h want 450f,450f", td[0], td[1]);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: got busy=%b want 0", busy1);
    end
  endtask

`ifdef VARREDOR_COMPARA_EN
  task automatic test_compara;
    int kd;
    int ke;
    kd = 0;
    ke = 0;
    modo1 = 2'd3;
    esp1 = TABELA_P3;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    esp1 = 16'h0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (erro1 && ke == 0) ke = k;
      if (done1) begin
        kd = k;
        break;
      end
    end
    n_chk++;
    if (ke != 30) begin
      n_fail++;
      $display("FAIL cmp_erro_cycle: got %0d want 30", ke);
    end
    n_chk++;
    if (kd != 33 || tab1 !== 16'h050F || n1 !== 5'd6) begin
      n_fail++;
      $display("FAIL cmp_table: got %0d/%h/%0d want 33/050f/6", kd, tab1, n1);
    end
    n_chk++;
    if (dut1.idx_erro !== 4'd14 || erro1 !== 1'b1) begin
      n_fail++;
      $display("FAIL cmp_index: got %0d/%b want 14/1", dut1.idx_erro, erro1);
    end
    modo1 = 2'd0;
  endtask
`endif

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_p3();
    test_const();
    test_restart_ignorado();
    test_reset_meio();
    test_back_to_back();
`ifdef VARREDOR_COMPARA_EN
    test_compara();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
